// File: rtl/pipe_ctrl_if.sv
// Hazard-controller port bundle: decoder/EX/MEM status in, pipeline enables, flushes,
// forwarding selects and performance counters out. Master drives the status side.
interface pipe_ctrl_if #(parameter int CNT_W = 16);
   logic             id_valid;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       id_rd;
   logic             id_regwrite;
   logic             id_memread;
   logic             id_memwrite;
   logic             ex_redirect;
   logic             mem_ready;
   logic             pc_en;
   logic             if_id_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, id_memwrite,
             ex_redirect, mem_ready,
      input  pc_en, if_id_en, if_id_flush, id_ex_flush, fwd_a, fwd_b, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, id_memwrite,
             ex_redirect, mem_ready,
      output pc_en, if_id_en, if_id_flush, id_ex_flush, fwd_a, fwd_b, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// RV32 5-stage hazard controller: shadow EX/MEM/WB scoreboard driving enables, flushes and
// forwarding selects combinationally (zero latency); mem stall freezes everything, saturating counters.
module pipe_ctrl #(
   parameter int CNT_W = 16
) (
   input logic        clk,
   input logic        rst_n,
   pipe_ctrl_if.slave bus
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
      logic       memread;
      logic       memop;
   } slot_t;

   slot_t            ex_q;
   slot_t            mem_q;
   slot_t            wb_q;
   slot_t            ex_d;
   logic             freeze;
   logic             lu_stall;
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   function automatic logic hit(input slot_t s, input logic [4:0] r);
      return s.valid && s.regwrite && (s.rd != 5'd0) && (s.rd == r);
   endfunction

   // A load still in EX has no data yet, so it is skipped here and stalls instead.
   function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem, input slot_t wb,
                                          input logic [4:0] r);
      if (hit(ex, r) && !ex.memread) return 2'b01;
      else if (hit(mem, r))          return 2'b10;
      else if (hit(wb, r))           return 2'b11;
      else                           return 2'b00;
   endfunction

   always_comb begin
      freeze   = mem_q.valid & mem_q.memop & ~bus.mem_ready;
      lu_stall = bus.id_valid & ~bus.ex_redirect & ex_q.memread &
                 (hit(ex_q, bus.id_rs1) | hit(ex_q, bus.id_rs2));
      ex_d     = '0;
      if (bus.id_valid && !lu_stall && !bus.ex_redirect) begin
         ex_d.valid    = 1'b1;
         ex_d.rd       = bus.id_rd;
         ex_d.regwrite = bus.id_regwrite;
         ex_d.memread  = bus.id_memread;
         ex_d.memop    = bus.id_memread | bus.id_memwrite;
      end
   end

   assign bus.pc_en       = ~freeze & (bus.ex_redirect | ~lu_stall);
   assign bus.if_id_en    = ~freeze & ~lu_stall;
   assign bus.if_id_flush = ~freeze & bus.ex_redirect;
   assign bus.id_ex_flush = ~freeze & (bus.ex_redirect | lu_stall);
   assign bus.fwd_a       = fwd_sel(ex_q, mem_q, wb_q, bus.id_rs1);
   assign bus.fwd_b       = fwd_sel(ex_q, mem_q, wb_q, bus.id_rs2);
   assign bus.stall_cnt   = stall_q;
   assign bus.flush_cnt   = flush_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (!freeze) begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= ex_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if ((freeze || lu_stall) && (stall_q != {CNT_W{1'b1}}))
            stall_q <= stall_q + CNT_W'(1);
         if (!freeze && bus.ex_redirect && (flush_q != {CNT_W{1'b1}}))
            flush_q <= flush_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized + directed bench for pipe_ctrl with a queue-based scoreboard and an
// instruction-level reference pipeline model.
module tb_pipe_ctrl;
   localparam int CNT_W = 16;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();
   pipe_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      bit v;
      int rd;
      bit rw;
      bit ld;
      bit mop;
   } instr_t;

   typedef struct {
      bit pc_en;
      bit if_id_en;
      bit if_id_flush;
      bit id_ex_flush;
      int fwd_a;
      int fwd_b;
      int sc;
      int fc;
   } exp_t;

   // index 0 = EX, 1 = MEM, 2 = WB
   instr_t pipe[3];
   int     m_sc, m_fc;
   exp_t   expq[$];
   int     checks = 0;
   int     failures = 0;
   bit     prev_freeze = 0;
   bit     prev_redir = 0;

   function automatic instr_t bubble();
      instr_t b;
      b.v = 0; b.rd = 0; b.rw = 0; b.ld = 0; b.mop = 0;
      return b;
   endfunction

   // Youngest in-flight producer of r, skipping a load still in EX.
   function int fwd_of(int r);
      if (r == 0) return 0;
      for (int k = 0; k < 3; k++)
         if (pipe[k].v && pipe[k].rw && pipe[k].rd == r && !(k == 0 && pipe[k].ld))
            return k + 1;
      return 0;
   endfunction

   function bit ex_load_hit(int r);
      return r != 0 && pipe[0].v && pipe[0].rw && pipe[0].ld && pipe[0].rd == r;
   endfunction

   task automatic step(bit rst, bit idv, int rs1, int rs2, int rd, bit rw, bit mr, bit mw,
                       bit redir, bit mready);
      exp_t   e;
      instr_t n;
      bit     fz, lu;
      @(posedge clk);
      #1;
      rst_n              = rst;
      bus.id_valid       = idv;
      bus.id_rs1         = 5'(rs1);
      bus.id_rs2         = 5'(rs2);
      bus.id_rd          = 5'(rd);
      bus.id_regwrite    = rw;
      bus.id_memread     = mr;
      bus.id_memwrite    = mw;
      bus.ex_redirect    = redir;
      bus.mem_ready      = mready;
      if (!rst) begin
         for (int k = 0; k < 3; k++) pipe[k] = bubble();
         m_sc = 0;
         m_fc = 0;
      end
      fz = pipe[1].v && pipe[1].mop && !mready;
      lu = idv && !redir && (ex_load_hit(rs1) || ex_load_hit(rs2));
      e.pc_en       = !fz && (redir || !lu);
      e.if_id_en    = !fz && !lu;
      e.if_id_flush = !fz && redir;
      e.id_ex_flush = !fz && (redir || lu);
      e.fwd_a       = fwd_of(rs1);
      e.fwd_b       = fwd_of(rs2);
      e.sc          = m_sc;
      e.fc          = m_fc;
      expq.push_back(e);
      if (rst) begin
         if ((fz || lu) && m_sc < CMAX) m_sc++;
         if (!fz && redir && m_fc < CMAX) m_fc++;
         if (!fz) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (idv && !lu && !redir) begin
               n.v = 1; n.rd = rd; n.rw = rw; n.ld = mr; n.mop = mr | mw;
               pipe[0] = n;
            end else begin
               pipe[0] = bubble();
            end
         end
      end
      prev_freeze = fz;
      prev_redir  = redir;
   endtask

   task automatic idle(bit redir = 0, bit mready = 1);
      step(1, 0, 0, 0, 0, 0, 0, 0, redir, mready);
   endtask

   task automatic chk(string name, int act, int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("pc_en",       int'(bus.pc_en),       int'(e.pc_en));
            chk("if_id_en",    int'(bus.if_id_en),    int'(e.if_id_en));
            chk("if_id_flush", int'(bus.if_id_flush), int'(e.if_id_flush));
            chk("id_ex_flush", int'(bus.id_ex_flush), int'(e.id_ex_flush));
            chk("fwd_a",       int'(bus.fwd_a),       e.fwd_a);
            chk("fwd_b",       int'(bus.fwd_b),       e.fwd_b);
            chk("stall_cnt",   int'(bus.stall_cnt),   e.sc);
            chk("flush_cnt",   int'(bus.flush_cnt),   e.fc);
         end
      end
   end

   initial begin
      bit mr, redir, mready, fz;
      rst_n = 1'b0;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle();
      idle();

      // Back-to-back ALU, then one and two independent instructions between.
      step(1, 1, 1, 2, 5, 1, 0, 0, 0, 1);
      step(1, 1, 5, 7, 6, 1, 0, 0, 0, 1);
      step(1, 1, 1, 2, 5, 1, 0, 0, 0, 1);
      step(1, 1, 8, 9, 10, 1, 0, 0, 0, 1);
      step(1, 1, 5, 7, 6, 1, 0, 0, 0, 1);
      step(1, 1, 1, 2, 5, 1, 0, 0, 0, 1);
      step(1, 1, 8, 9, 10, 1, 0, 0, 0, 1);
      step(1, 1, 8, 9, 11, 1, 0, 0, 0, 1);
      step(1, 1, 5, 7, 6, 1, 0, 0, 0, 1);
      idle(); idle(); idle();

      // Load-use: one stall, then forward from MEM.
      step(1, 1, 1, 0, 5, 1, 1, 0, 0, 1);
      step(1, 1, 3, 5, 6, 1, 0, 0, 0, 1);
      step(1, 1, 3, 5, 6, 1, 0, 0, 0, 1);
      idle(); idle(); idle();

      // x0 never hazards.
      step(1, 1, 0, 0, 0, 1, 0, 0, 0, 1);
      step(1, 1, 0, 0, 1, 1, 0, 0, 0, 1);
      idle(); idle(); idle();

      // Redirect coinciding with a load-use match.
      step(1, 1, 1, 0, 5, 1, 1, 0, 0, 1);
      step(1, 1, 5, 0, 6, 1, 0, 0, 1, 1);
      idle(); idle(); idle();

      // Store stalls in MEM for 3 cycles with a redirect held in EX.
      step(1, 1, 1, 2, 0, 0, 0, 1, 0, 1);
      step(1, 1, 3, 4, 7, 1, 0, 0, 0, 1);
      idle(1, 0); idle(1, 0); idle(1, 0);
      idle(1, 1);
      idle(); idle(); idle();

      // Randomized traffic on a small register set to provoke hazards.
      for (int i = 0; i < 3000; i++) begin
         mready = ($urandom_range(0, 3) != 0);
         fz     = pipe[1].v && pipe[1].mop && !mready;
         if (prev_freeze) redir = prev_redir;
         else             redir = ($urandom_range(0, 7) == 0);
         mr = ($urandom_range(0, 2) == 0);
         step(1, bit'($urandom_range(0, 4) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), bit'($urandom_range(0, 3) != 0), mr,
              !mr && ($urandom_range(0, 3) == 0), redir, mready);
         if (fz && i % 997 == 0) idle(redir, 0);
      end
      idle(prev_freeze ? prev_redir : 1'b0, 1);
      idle(); idle(); idle();

      // Long freeze drives stall_cnt into saturation.
      step(1, 1, 0, 0, 0, 0, 0, 1, 0, 1);
      idle();
      while (m_sc < CMAX - 1) idle(0, 0);
      idle(0, 0); idle(0, 0); idle(0, 0);

      // Asynchronous reset while frozen, then a fresh instruction.
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 1, 5, 6, 7, 1, 0, 0, 0, 1);
      idle();

      @(negedge clk);
      #1;
      chk("scoreboard_drained", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard controller for the 5-stage RV32 core. It sits beside the ID stage and keeps a shadow scoreboard of the EX, MEM and WB slots, fed by the decoder's control outputs. Each cycle it produces the PC and pipeline-register enables and flushes, the bubble insertion, and the forwarding selects for the EX operand muxes. It also keeps saturating stall and flush performance counters.

## Interface
- CNT_W, 16, width of each performance counter
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5 each  decoder source addresses (0 = unused)
- id_rd  in  5  decoder destination address
- id_regwrite, id_memread, id_memwrite  in  1 each  decoder control bits
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle
- mem_ready  in  1  data memory completes the access in MEM this cycle
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID register loads a NOP
- id_ex_flush  out  1  ID/EX register loads a bubble
- fwd_a, fwd_b  out  2 each  operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB
- stall_cnt  out  CNT_W  cycles lost to stalls
- flush_cnt  out  CNT_W  redirect events

## Operation
- Scoreboard slots are EX, MEM and WB. Each slot holds {valid, rd, regwrite, memread, memop}, where memop = memread|memwrite.
- freeze = MEM.valid & MEM.memop & !mem_ready.
- hit(S, r) = S.valid & S.regwrite & S.rd != 0 & S.rd == r. Register x0 never hazards.
- lu_stall = id_valid & !ex_redirect & EX.memread & (hit(EX, id_rs1) | hit(EX, id_rs2)).
- Enables and flushes:
  - pc_en = !freeze & (ex_redirect | !lu_stall)
  - if_id_en = !freeze & !lu_stall
  - if_id_flush = !freeze & ex_redirect
  - id_ex_flush = !freeze & (ex_redirect | lu_stall)
- Slot advance, only when !freeze:
  - WB <= MEM, and MEM <= EX.
  - EX <= bubble (valid=0) if !id_valid, lu_stall or ex_redirect.
  - Otherwise EX <= {1, id_rd, id_regwrite, id_memread, id_memread|id_memwrite}.
- While freeze is high, all slots hold.
- Forwarding (fwd_a uses id_rs1, fwd_b uses id_rs2; combinational):
  - The result is valid in the cycle the instruction leaves ID.
  - Priority: hit(EX) & !EX.memread → 01, else hit(MEM) → 10, else hit(WB) → 11, else 00.
  - An EX-slot load hit never forwards; it raises lu_stall instead.
- Priority between events: freeze > ex_redirect > lu_stall.
  - During freeze, EX must hold ex_redirect stable. The redirect acts on the first non-frozen cycle.
- Counters:
  - stall_cnt increments in any cycle with freeze | lu_stall.
  - flush_cnt increments on each non-frozen cycle with ex_redirect.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (rst_n low, asynchronous): all slots invalid; stall_cnt = flush_cnt = 0.
- With an idle ID after reset, outputs read pc_en = 1, if_id_en = 1, if_id_flush = 0, id_ex_flush = 0, fwd_a = fwd_b = 00.
- Reset release is synchronous to the next clk rising edge.
- Control outputs are combinational from the slot registers and the current-cycle inputs. There is no added latency, and no output depends on itself.
- A load-use hazard costs exactly one stall cycle. In the next cycle the load occupies MEM and forwarding gives 10.
- A redirect costs two instructions: IF/ID and the ID instruction are squashed in the same edge.
- A mem stall of N cycles holds every enable low for N cycles. Forwarding selects stay stable throughout.
- Reset mid-stall clears the scoreboard immediately. The first post-reset instruction sees no hazard.

## Test plan
- **Back-to-back ALU:** add x5 then add x6,x5,x7.
  - Second instruction in ID → fwd_a = 01, no stall, pc_en = 1.
  - With one independent instruction between them → fwd_a = 10. With two between → 11.
- **Load-use:** lw x5 in EX, ID reads rs2 = x5.
  - Exactly one cycle with pc_en = 0, if_id_en = 0, id_ex_flush = 1.
  - Next cycle fwd_b = 10, and stall_cnt goes from 0 to 1.
- **x0 immunity:** addi x0 followed by add x1,x0,x0 → fwd_a = fwd_b = 00 and no stall.
- **Redirect over load-use:** ex_redirect = 1 at the same time as a load-use match.
  - if_id_flush = 1, id_ex_flush = 1, pc_en = 1; the stall is suppressed.
  - flush_cnt goes to 1 and stall_cnt is unchanged.
- **Mem stall:** sw in MEM with mem_ready low for 3 cycles while ex_redirect is held.
  - All enables and flushes are 0 for those 3 cycles, and stall_cnt increases by 3.
  - Flushes fire on the 4th cycle.
- **Saturation and reset:** force stall_cnt to 16'hFFFE, then apply 3 stall cycles → it reads 16'hFFFF.
  - Asserting rst_n low mid-stall → counters 0 and pc_en = 1 with no clock edge.
